// File: rtl/ser_to_par.sv
// ser_to_par: LSB-first serial-to-parallel converter with a decoupled
// output word register and sticky overflow flag.
// Optional feature macro: SER_TO_PAR_PARITY_EN adds one even-parity bit
// after each DATA_W data bits, the PAR state and the parity_err_o pulse.
//
// Handshake: an input bit transfers on every rising clk edge with
// valid_i=1 (no backpressure on the serial side). An output word transfers
// on every rising clk edge with valid_o=1 and ready_i=1; while valid_o=1 and
// ready_i=0, parallel_o and valid_o hold steady.
module ser_to_par #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_i,
  input  logic              valid_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] parallel_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              overflow_o,
`ifdef SER_TO_PAR_PARITY_EN
  output logic              parity_err_o,
`endif
  output logic [1:0]        state_dbg_o
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SER_TO_PAR_PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              parity_err_q, parity_err_d;
  logic [DATA_W-1:0] word_ins;
  logic [DATA_W-1:0] done_word;
  logic              word_done;

  // State register: capture path, output word register and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      out_q        <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Next-state: place incoming bit at its index, complete words, and
  // resolve completion against the held word (consume / load / drop).
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    out_d        = out_q;
    valid_d      = valid_q;
    overflow_d   = overflow_q;
    parity_err_d = 1'b0;
    word_done    = 1'b0;
    done_word    = '0;

    // Shift register with the current bit written at position count_q.
    word_ins = shift_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (count_q == CW'(i)) word_ins[i] = serial_i;
    end

    if (valid_q && ready_i) valid_d = 1'b0;

    if (valid_i) begin
      case (state_q)
        IDLE: begin
          shift_d = word_ins;
          count_d = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          shift_d = word_ins;
          if (count_q == CW'(DATA_W - 1)) begin
`ifdef SER_TO_PAR_PARITY_EN
            count_d = CW'(DATA_W);
            state_d = PAR;
`else
            word_done = 1'b1;
            done_word = word_ins;
            shift_d   = '0;
            count_d   = '0;
            state_d   = IDLE;
`endif
          end else begin
            count_d = count_q + CW'(1);
          end
        end
`ifdef SER_TO_PAR_PARITY_EN
        PAR: begin
          // Even parity: data bits XOR parity bit must be zero.
          if ((^shift_q ^ serial_i) == 1'b0) begin
            word_done = 1'b1;
            done_word = shift_q;
          end else begin
            parity_err_d = 1'b1;
          end
          shift_d = '0;
          count_d = '0;
          state_d = IDLE;
        end
`endif
        default: begin
          shift_d = '0;
          count_d = '0;
          state_d = IDLE;
        end
      endcase
    end

    // A held word that is not being consumed wins; the new one is dropped.
    if (word_done) begin
      if (valid_q && !ready_i) begin
        overflow_d = 1'b1;
      end else begin
        out_d   = done_word;
        valid_d = 1'b1;
      end
    end
  end

  assign parallel_o  = out_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != IDLE);
  assign overflow_o  = overflow_q;
  assign state_dbg_o = state_q;
`ifdef SER_TO_PAR_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  // Parity pulse exists only in the parity build; keep the flop tied off.
  logic unused_parity;
  assign unused_parity = parity_err_q;
`endif

endmodule

// File: tb/tb_ser_to_par.sv
// tb_ser_to_par: directed bench for ser_to_par (DATA_W=4).
// Inputs change 1 time unit after each rising edge; outputs are checked
// at the same point, i.e. after the edge that sampled the last input.
module tb_ser_to_par;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         serial_i;
  logic         valid_i;
  logic         ready_i;
  logic [W-1:0] parallel_o;
  logic         valid_o;
  logic         busy_o;
  logic         overflow_o;
  logic [1:0]   state_dbg_o;
`ifdef SER_TO_PAR_PARITY_EN
  logic         parity_err_o;
`endif

  int checks = 0;
  int errors = 0;

  ser_to_par #(.DATA_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_i    (serial_i),
    .valid_i     (valid_i),
    .ready_i     (ready_i),
    .parallel_o  (parallel_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
`ifdef SER_TO_PAR_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .state_dbg_o (state_dbg_o)
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid bit for exactly one edge.
  task automatic send_bit(input logic b);
    serial_i = b;
    valid_i  = 1'b1;
    tick();
    valid_i  = 1'b0;
    serial_i = 1'b0;
  endtask

  // Trailing even-parity bit in the parity build; nothing otherwise.
  task automatic send_parity(input logic [W-1:0] w);
`ifdef SER_TO_PAR_PARITY_EN
    send_bit(^w);
`else
    w = w;
`endif
  endtask

  // Full word LSB first; optionally raise ready_i for the completing edge.
  task automatic send_word(input logic [W-1:0] w, input logic rdy_last);
    for (int i = 0; i < W; i++) begin
`ifndef SER_TO_PAR_PARITY_EN
      if (i == W - 1 && rdy_last) ready_i = 1'b1;
`endif
      send_bit(w[i]);
    end
`ifdef SER_TO_PAR_PARITY_EN
    if (rdy_last) ready_i = 1'b1;
`endif
    send_parity(w);
  endtask

  initial begin
    reset    = 1'b0;
    serial_i = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_valid", 16'(valid_o), 16'h0);
    check("rst_par", 16'(parallel_o), 16'h0);
    check("rst_busy", 16'(busy_o), 16'h0);
    check("rst_ovf", 16'(overflow_o), 16'h0);
    check("rst_state", 16'(state_dbg_o), 16'h0);
    reset = 1'b1;
    tick();

    // Bits 1,0,1,1 back to back, ready high -> 4'hD
    ready_i = 1'b1;
    send_bit(1'b1);
    check("d_busy1", 16'(busy_o), 16'h1);
    check("d_state1", 16'(state_dbg_o), 16'h1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("d_valid_early", 16'(valid_o), 16'h0);
    send_bit(1'b1);
    send_parity(4'hD);
    check("d_valid", 16'(valid_o), 16'h1);
    check("d_par", 16'(parallel_o), 16'hD);
    check("d_busy_done", 16'(busy_o), 16'h0);
    tick();
    check("d_valid_drop", 16'(valid_o), 16'h0);

    // Bits 0,1, five-cycle gap, 1,0 -> 4'h6
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gap_busy", 16'(busy_o), 16'h1);
    end
    check("gap_valid", 16'(valid_o), 16'h0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_parity(4'h6);
    check("gap_valid_done", 16'(valid_o), 16'h1);
    check("gap_par", 16'(parallel_o), 16'h6);
    tick();
    check("gap_valid_drop", 16'(valid_o), 16'h0);

    // Overflow: ready low, word A then word 3
    ready_i = 1'b0;
    send_word(4'hA, 1'b0);
    check("ovf_valid_a", 16'(valid_o), 16'h1);
    check("ovf_par_a", 16'(parallel_o), 16'hA);
    check("ovf_flag_a", 16'(overflow_o), 16'h0);
    send_word(4'h3, 1'b0);
    check("ovf_par_kept", 16'(parallel_o), 16'hA);
    check("ovf_valid_kept", 16'(valid_o), 16'h1);
    check("ovf_flag", 16'(overflow_o), 16'h1);
    ready_i = 1'b1;
    tick();
    check("ovf_valid_cons", 16'(valid_o), 16'h0);
    check("ovf_flag_sticky", 16'(overflow_o), 16'h1);
    tick();
    check("ovf_flag_sticky2", 16'(overflow_o), 16'h1);

    // Reset mid-word: asynchronous clear, then 1,1,1,1 -> 4'hF
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_busy", 16'(busy_o), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 16'(busy_o), 16'h0);
    check("mid_rst_ovf", 16'(overflow_o), 16'h0);
    check("mid_rst_par", 16'(parallel_o), 16'h0);
    check("mid_rst_state", 16'(state_dbg_o), 16'h0);
    #1;
    reset = 1'b1;
    tick();
    send_word(4'hF, 1'b0);
    check("mid_valid", 16'(valid_o), 16'h1);
    check("mid_par", 16'(parallel_o), 16'hF);
    tick();
    check("mid_valid_drop", 16'(valid_o), 16'h0);

    // Back-to-back: 5 held, C completes on the consuming edge
    ready_i = 1'b0;
    send_word(4'h5, 1'b0);
    check("b2b_valid_5", 16'(valid_o), 16'h1);
    check("b2b_par_5", 16'(parallel_o), 16'h5);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("b2b_hold_par", 16'(parallel_o), 16'h5);
    check("b2b_hold_valid", 16'(valid_o), 16'h1);
`ifndef SER_TO_PAR_PARITY_EN
    ready_i = 1'b1;
`endif
    send_bit(1'b1);
`ifdef SER_TO_PAR_PARITY_EN
    ready_i = 1'b1;
`endif
    send_parity(4'hC);
    check("b2b_valid_c", 16'(valid_o), 16'h1);
    check("b2b_par_c", 16'(parallel_o), 16'hC);
    check("b2b_ovf", 16'(overflow_o), 16'h0);
    tick();
    check("b2b_valid_drop", 16'(valid_o), 16'h0);

`ifdef SER_TO_PAR_PARITY_EN
    // Parity: 7 with parity 1 accepted, 7 with parity 0 rejected
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("par_state", 16'(state_dbg_o), 16'h2);
    check("par_busy", 16'(busy_o), 16'h1);
    send_bit(1'b1);
    check("par_ok_valid", 16'(valid_o), 16'h1);
    check("par_ok_par", 16'(parallel_o), 16'h7);
    check("par_ok_err", 16'(parity_err_o), 16'h0);
    tick();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("par_bad_err", 16'(parity_err_o), 16'h1);
    check("par_bad_valid", 16'(valid_o), 16'h0);
    check("par_bad_busy", 16'(busy_o), 16'h0);
    tick();
    check("par_bad_err_end", 16'(parity_err_o), 16'h0);
    check("par_bad_valid2", 16'(valid_o), 16'h0);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
